// File: rtl/prop_checker.sv
// On-chip checker for a&b, a|b, a|->b and a|=>b with saturating pass/fail/vacuous counters.
// Define PROP_CHK_STAMP_EN to add the first_fail_cyc cycle stamp of the first failure.
module prop_checker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             stop,
    input  logic             halt_on_fail,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] vac_cnt,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic             fail_pulse,
    output logic             fail_sticky
`ifdef PROP_CHK_STAMP_EN
    ,
    output logic [CNT_W-1:0] first_fail_cyc
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [1:0] MODE_AND  = 2'd0;
    localparam logic [1:0] MODE_OR   = 2'd1;
    localparam logic [1:0] MODE_IMPL = 2'd2;
    localparam logic [1:0] MODE_NEXT = 2'd3;

    state_t     state_q, state_d;
    logic [1:0] mode_q;
    logic       pend_q;
    logic       eval;
    logic       pass_hit, fail_hit, vac_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign state = state_q;

    // start and stop both pre-empt evaluation on the edge they are seen
    assign eval = (state_q == ST_RUN) && !start && !stop;

    always_comb begin
        pass_hit = 1'b0;
        fail_hit = 1'b0;
        vac_hit  = 1'b0;
        if (eval) begin
            case (mode_q)
                MODE_AND: begin
                    pass_hit = a & b;
                    fail_hit = ~(a & b);
                end
                MODE_OR: begin
                    pass_hit = a | b;
                    fail_hit = ~(a | b);
                end
                MODE_IMPL: begin
                    vac_hit  = ~a;
                    pass_hit = a & b;
                    fail_hit = a & ~b;
                end
                default: begin
                    // Older attempt resolves on this edge's b before a new one is opened
                    pass_hit = pend_q & b;
                    fail_hit = pend_q & ~b;
                    vac_hit  = ~a;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (start)                         state_d = ST_RUN;
                else if (stop)                     state_d = ST_HALT;
                else if (fail_hit && halt_on_fail) state_d = ST_HALT;
            end
            ST_HALT: if (start) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_AND;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) mode_q <= mode;
            // Pending survives only an evaluation edge that stays in RUN
            pend_q <= eval && (mode_q == MODE_NEXT) && a && (state_d == ST_RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || (start && rst_n)) begin
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            vac_cnt     <= '0;
            cyc_cnt     <= '0;
            fail_pulse  <= 1'b0;
            fail_sticky <= 1'b0;
        end else begin
            fail_pulse <= fail_hit;
            if (eval) begin
                cyc_cnt <= sat_inc(cyc_cnt);
                if (pass_hit) pass_cnt <= sat_inc(pass_cnt);
                if (fail_hit) fail_cnt <= sat_inc(fail_cnt);
                if (vac_hit)  vac_cnt  <= sat_inc(vac_cnt);
                if (fail_hit) fail_sticky <= 1'b1;
            end
        end
    end

`ifdef PROP_CHK_STAMP_EN
    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            first_fail_cyc <= '0;
        end else if (fail_hit && !fail_sticky) begin
            first_fail_cyc <= sat_inc(cyc_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_prop_checker.sv
// Scoreboarded bench for prop_checker: a behavioural model queues expected outputs per edge,
// a monitor compares them, and each scenario task adds its own directed checks.
module tb_prop_checker;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             a = 1'b0, b = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic             start = 1'b0, stop = 1'b0, halt_on_fail = 1'b0;
    logic [1:0]       state;
    logic [CNT_W-1:0] pass_cnt, fail_cnt, vac_cnt, cyc_cnt;
    logic             fail_pulse, fail_sticky;
`ifdef PROP_CHK_STAMP_EN
    logic [CNT_W-1:0] first_fail_cyc;
`endif

    prop_checker #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .mode(mode),
        .start(start), .stop(stop), .halt_on_fail(halt_on_fail),
        .state(state), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .vac_cnt(vac_cnt), .cyc_cnt(cyc_cnt),
        .fail_pulse(fail_pulse), .fail_sticky(fail_sticky)
`ifdef PROP_CHK_STAMP_EN
        , .first_fail_cyc(first_fail_cyc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       st;
        logic [CNT_W-1:0] pass, fail, vac, cyc, ffc;
        logic             pulse, sticky;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    int   m_state, m_mode, m_pend, m_pass, m_fail, m_vac, m_cyc, m_ffc, m_pulse, m_sticky;

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic push_exp();
        exp_t e;
        e.st = 2'(m_state);
        e.pass = CNT_W'(m_pass);
        e.fail = CNT_W'(m_fail);
        e.vac = CNT_W'(m_vac);
        e.cyc = CNT_W'(m_cyc);
        e.ffc = CNT_W'(m_ffc);
        e.pulse = (m_pulse != 0);
        e.sticky = (m_sticky != 0);
        sb_q.push_back(e);
    endtask

    task automatic model_clear();
        m_pass = 0; m_fail = 0; m_vac = 0; m_cyc = 0; m_ffc = 0;
        m_pulse = 0; m_sticky = 0; m_pend = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        model_clear();
        m_state = 0; m_mode = 0;
        push_exp();
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic step(input logic st, input logic sp, input logic [1:0] md,
                        input logic hof, input logic aa, input logic bb);
        int p, f, v;
        start = st; stop = sp; mode = md; halt_on_fail = hof; a = aa; b = bb;
        m_pulse = 0;
        if (st) begin
            model_clear();
            m_mode = md;
            m_state = 1;
        end else if (sp) begin
            if (m_state == 1) m_state = 2;
            m_pend = 0;
        end else if (m_state == 1) begin
            p = 0; f = 0; v = 0;
            case (m_mode)
                0: if (aa && bb) p = 1; else f = 1;
                1: if (aa || bb) p = 1; else f = 1;
                2: if (!aa) v = 1; else if (bb) p = 1; else f = 1;
                default: begin
                    if (m_pend != 0) begin
                        if (bb) p = 1; else f = 1;
                    end
                    m_pend = aa ? 1 : 0;
                    if (!aa) v = 1;
                end
            endcase
            m_cyc = sat(m_cyc);
            if (p != 0) m_pass = sat(m_pass);
            if (f != 0) m_fail = sat(m_fail);
            if (v != 0) m_vac = sat(m_vac);
            if (f != 0) begin
                m_pulse = 1;
                if (m_sticky == 0) begin
                    m_sticky = 1;
                    m_ffc = m_cyc;
                end
                if (hof) begin
                    m_state = 2;
                    m_pend = 0;
                end
            end
        end
        push_exp();
        @(posedge clk); #2;
        start = 1'b0; stop = 1'b0;
    endtask

    // Scoreboard monitor: compares one queued expectation per edge, 1 time unit after it
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (state !== e.st || pass_cnt !== e.pass || fail_cnt !== e.fail ||
                    vac_cnt !== e.vac || cyc_cnt !== e.cyc || fail_pulse !== e.pulse ||
                    fail_sticky !== e.sticky) begin
                    n_errors++;
                    $display("FAIL sb_outputs t=%0t: got st=%0d p=%0d f=%0d v=%0d c=%0d pl=%b sk=%b expected st=%0d p=%0d f=%0d v=%0d c=%0d pl=%b sk=%b",
                             $time, state, pass_cnt, fail_cnt, vac_cnt, cyc_cnt, fail_pulse, fail_sticky,
                             e.st, e.pass, e.fail, e.vac, e.cyc, e.pulse, e.sticky);
                end
`ifdef PROP_CHK_STAMP_EN
                n_checks++;
                if (first_fail_cyc !== e.ffc) begin
                    n_errors++;
                    $display("FAIL sb_first_fail_cyc t=%0t: got %0d expected %0d", $time, first_fail_cyc, e.ffc);
                end
`endif
            end
        end
    end

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (state !== 2'd0 || pass_cnt !== '0 || fail_cnt !== '0 || vac_cnt !== '0 ||
            cyc_cnt !== '0 || fail_pulse !== 1'b0 || fail_sticky !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got st=%0d p=%0d f=%0d v=%0d c=%0d pl=%b sk=%b expected all zero",
                     state, pass_cnt, fail_cnt, vac_cnt, cyc_cnt, fail_pulse, fail_sticky);
        end
    endtask

    task automatic test_mode0_basic();
        int pulses = 0;
        step(1, 0, 2'd0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 2'd0, 0, 1, 1);
            if (fail_pulse) pulses++;
        end
        step(0, 0, 2'd0, 0, 1, 0);
        if (fail_pulse) pulses++;
        step(0, 1, 2'd0, 0, 0, 0);
        if (fail_pulse) pulses++;
        n_checks++;
        if (pass_cnt !== CNT_W'(4) || fail_cnt !== CNT_W'(1) || cyc_cnt !== CNT_W'(5) ||
            fail_sticky !== 1'b1 || state !== 2'd2 || pulses != 1) begin
            n_errors++;
            $display("FAIL mode0_basic: got p=%0d f=%0d c=%0d sk=%b st=%0d pulses=%0d expected p=4 f=1 c=5 sk=1 st=2 pulses=1",
                     pass_cnt, fail_cnt, cyc_cnt, fail_sticky, state, pulses);
        end
`ifdef PROP_CHK_STAMP_EN
        n_checks++;
        if (first_fail_cyc !== CNT_W'(5)) begin
            n_errors++;
            $display("FAIL mode0_stamp: got %0d expected 5", first_fail_cyc);
        end
`endif
    endtask

    task automatic test_mode3_seq();
        step(1, 0, 2'd3, 0, 0, 0);
        step(0, 0, 2'd0, 0, 1, 1);
        step(0, 0, 2'd0, 0, 0, 0);
        n_checks++;
        if (fail_cnt !== CNT_W'(1) || fail_pulse !== 1'b1) begin
            n_errors++;
            $display("FAIL mode3_edge2: got f=%0d pl=%b expected f=1 pl=1", fail_cnt, fail_pulse);
        end
        step(0, 0, 2'd0, 0, 1, 1);
        step(0, 0, 2'd0, 0, 0, 1);
        n_checks++;
        if (vac_cnt !== CNT_W'(2) || fail_cnt !== CNT_W'(1) || pass_cnt !== CNT_W'(1)) begin
            n_errors++;
            $display("FAIL mode3_seq: got v=%0d f=%0d p=%0d expected v=2 f=1 p=1", vac_cnt, fail_cnt, pass_cnt);
        end
`ifdef PROP_CHK_STAMP_EN
        n_checks++;
        if (first_fail_cyc !== CNT_W'(2)) begin
            n_errors++;
            $display("FAIL mode3_stamp: got %0d expected 2", first_fail_cyc);
        end
`endif
    endtask

    task automatic test_halt_on_fail();
        step(1, 0, 2'd1, 1, 0, 0);
        step(0, 0, 2'd1, 1, 1, 0);
        step(0, 0, 2'd1, 1, 0, 1);
        step(0, 0, 2'd1, 1, 0, 0);
        n_checks++;
        if (state !== 2'd2 || pass_cnt !== CNT_W'(2) || fail_cnt !== CNT_W'(1) || cyc_cnt !== CNT_W'(3)) begin
            n_errors++;
            $display("FAIL halt_on_fail: got st=%0d p=%0d f=%0d c=%0d expected st=2 p=2 f=1 c=3",
                     state, pass_cnt, fail_cnt, cyc_cnt);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 2'd0, 1, 1, 1);
        n_checks++;
        if (state !== 2'd2 || pass_cnt !== CNT_W'(2) || fail_cnt !== CNT_W'(1) ||
            cyc_cnt !== CNT_W'(3) || fail_sticky !== 1'b1) begin
            n_errors++;
            $display("FAIL halt_frozen: got st=%0d p=%0d f=%0d c=%0d sk=%b expected st=2 p=2 f=1 c=3 sk=1",
                     state, pass_cnt, fail_cnt, cyc_cnt, fail_sticky);
        end
    endtask

    task automatic test_saturation();
        step(1, 0, 2'd0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 2'd0, 0, 1, 1);
        n_checks++;
        if (pass_cnt !== CNT_W'(15) || cyc_cnt !== CNT_W'(15) || fail_cnt !== '0) begin
            n_errors++;
            $display("FAIL saturation: got p=%0d c=%0d f=%0d expected p=15 c=15 f=0", pass_cnt, cyc_cnt, fail_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        step(1, 0, 2'd3, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 2'd3, 0, 1, 0);
        n_checks++;
        if (fail_cnt !== CNT_W'(3)) begin
            n_errors++;
            $display("FAIL midrun_setup: got f=%0d expected 3", fail_cnt);
        end
        do_reset();
        n_checks++;
        if (state !== 2'd0 || pass_cnt !== '0 || fail_cnt !== '0 || vac_cnt !== '0 ||
            cyc_cnt !== '0 || fail_sticky !== 1'b0) begin
            n_errors++;
            $display("FAIL midrun_reset: got st=%0d p=%0d f=%0d v=%0d c=%0d sk=%b expected all zero",
                     state, pass_cnt, fail_cnt, vac_cnt, cyc_cnt, fail_sticky);
        end
        step(1, 0, 2'd3, 0, 0, 0);
        step(0, 0, 2'd3, 0, 0, 0);
        n_checks++;
        if (fail_cnt !== '0 || vac_cnt !== CNT_W'(1) || fail_sticky !== 1'b0) begin
            n_errors++;
            $display("FAIL midrun_no_pending: got f=%0d v=%0d sk=%b expected f=0 v=1 sk=0", fail_cnt, vac_cnt, fail_sticky);
        end
    endtask

    task automatic test_restart();
        step(1, 0, 2'd0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 2'd0, 0, 1, 1);
        step(1, 1, 2'd2, 0, 0, 0);
        n_checks++;
        if (state !== 2'd1 || pass_cnt !== '0 || cyc_cnt !== '0 || vac_cnt !== '0) begin
            n_errors++;
            $display("FAIL restart_clear: got st=%0d p=%0d c=%0d v=%0d expected st=1 p=0 c=0 v=0",
                     state, pass_cnt, cyc_cnt, vac_cnt);
        end
        step(0, 0, 2'd0, 0, 0, 0);
        n_checks++;
        if (vac_cnt !== CNT_W'(1) || fail_cnt !== '0) begin
            n_errors++;
            $display("FAIL restart_mode2: got v=%0d f=%0d expected v=1 f=0", vac_cnt, fail_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int hi = 0;
        step(1, 0, 2'd0, 0, 0, 0);
        step(0, 0, 2'd0, 0, 0, 0);
        if (fail_pulse === 1'b1) hi++;
        step(0, 0, 2'd0, 0, 1, 0);
        if (fail_pulse === 1'b1) hi++;
        step(0, 0, 2'd0, 0, 1, 1);
        n_checks++;
        if (hi != 2 || fail_pulse !== 1'b0 || fail_cnt !== CNT_W'(2)) begin
            n_errors++;
            $display("FAIL back_to_back: got high=%0d last=%b f=%0d expected high=2 last=0 f=2", hi, fail_pulse, fail_cnt);
        end
    endtask

    task automatic test_random();
        logic [1:0] md;
        step(1, 0, 2'($urandom_range(0, 3)), 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            md = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0), md,
                 ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_mode0_basic();
        test_mode3_seq();
        test_halt_on_fail();
        test_saturation();
        test_reset_mid_run();
        test_restart();
        test_back_to_back();
        test_random();
        @(posedge clk); #3;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
